// File: rtl/sc_dot_product_decoder.sv
// Windowed ones-counter for the stochastic dot-product stream: counts ones over
// 2^WIDTH bits and presents the rescaled binary result on a valid/ready handshake.
module sc_dot_product_decoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIMENSION = 4,
    parameter int unsigned OUT_W     = 2 * WIDTH + $clog2(DIMENSION) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] result,
    output logic [WIDTH:0]   ones_count,
    output logic             busy,
    output logic             aborted
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam int unsigned L     = 2 ** WIDTH;
    localparam int unsigned SHIFT = WIDTH + $clog2(DIMENSION);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               busy_q, busy_d;
    logic               aborted_q, aborted_d;
    logic [CNT_W-1:0]   acc_inc;

    // Window framing, accumulation and result hand-off
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ones_d      = ones_q;
        aborted_d   = 1'b0;
        acc_inc     = acc_q + CNT_W'(in_bit);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = CNT_W'(in_bit);
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    // cnt_q is the index of the sample captured on this edge
                    if (cnt_q == CNT_W'(L - 1)) begin
                        ones_d      = acc_inc;
                        result_d    = OUT_W'(acc_inc) << SHIFT;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = DONE;
                    end else begin
                        acc_d = acc_inc;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ones_q      <= '0;
            busy_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ones_q      <= ones_d;
            busy_q      <= busy_d;
            aborted_q   <= aborted_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign ones_count = ones_q;
    assign busy       = busy_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_sc_dot_product_decoder.sv
// Directed bench for sc_dot_product_decoder with hand-computed window results.
module tb_sc_dot_product_decoder;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DIMENSION = 4;
    localparam int unsigned OUT_W     = 19;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] result;
    logic [WIDTH:0]   ones_count;
    logic             busy;
    logic             aborted;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;
    int ab_cnt = 0;

    sc_dot_product_decoder #(.WIDTH(WIDTH), .DIMENSION(DIMENSION)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .result     (result),
        .ones_count (ones_count),
        .busy       (busy),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    // Cycle counters for out_valid and aborted (value held during the preceding cycle)
    always @(posedge clk) begin
        if (out_valid) ov_cnt = ov_cnt + 1;
        if (aborted)   ab_cnt = ab_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mode 0: ones, 1: zeros, 2: alternating 1,0, 3: 64 ones then zeros
    function automatic logic bit_of(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2 == 0);
            default: return (i < 64);
        endcase
    endfunction

    // Drive n in_valid samples, then deassert in_valid on the following negedge
    task automatic stream(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = bit_of(mode, i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        #12;
        checks++;
        if ({out_valid, result, ones_count, busy, aborted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b res=%0d ones=%0d busy=%b ab=%b required all 0",
                     out_valid, result, ones_count, busy, aborted);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        out_ready = 1'b1;
        ov_cnt = 0;
        stream(0, 256);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL ones_valid: got %b required 1", out_valid);
        end
        checks++;
        if (ones_count !== 9'd256) begin
            errors++; $display("FAIL ones_count: got %0d required 256", ones_count);
        end
        checks++;
        if (result !== 19'd262144) begin
            errors++; $display("FAIL ones_result: got %0d required 262144", result);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ones_busy_fall: got %b required 0", busy);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ov_cnt !== 1) begin
            errors++; $display("FAIL ones_pulse: got ov=%b cycles=%0d required ov=0 cycles=1", out_valid, ov_cnt);
        end
    endtask

    task automatic test_all_zeros();
        ov_cnt = 0;
        stream(1, 256);
        checks++;
        if (out_valid !== 1'b1 || ones_count !== 9'd0 || result !== 19'd0) begin
            errors++;
            $display("FAIL zeros_window: got ov=%b ones=%0d res=%0d required ov=1 ones=0 res=0",
                     out_valid, ones_count, result);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (ov_cnt !== 1) begin
            errors++; $display("FAIL zeros_pulse: got %0d cycles required 1", ov_cnt);
        end
    endtask

    // Two alternating windows on a continuous stream; the bit on the handshake edge is ignored
    task automatic test_back_to_back();
        ov_cnt = 0;
        for (int k = 0; k < 513; k++) begin
            @(negedge clk);
            if (k == 256) begin
                checks++;
                if (out_valid !== 1'b1 || ones_count !== 9'd128 || result !== 19'd131072) begin
                    errors++;
                    $display("FAIL b2b_first: got ov=%b ones=%0d res=%0d required ov=1 ones=128 res=131072",
                             out_valid, ones_count, result);
                end
            end
            in_valid = 1'b1;
            if (k < 256)       in_bit = bit_of(2, k);
            else if (k == 256) in_bit = 1'b1;
            else               in_bit = bit_of(2, k - 257);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ones_count !== 9'd128 || result !== 19'd131072) begin
            errors++;
            $display("FAIL b2b_second: got ov=%b ones=%0d res=%0d required ov=1 ones=128 res=131072",
                     out_valid, ones_count, result);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (ov_cnt !== 2) begin
            errors++; $display("FAIL b2b_pulses: got %0d cycles required 2", ov_cnt);
        end
    endtask

    task automatic test_abort();
        ov_cnt = 0;
        ab_cnt = 0;
        stream(0, 100);
        checks++;
        if (busy !== 1'b1 || aborted !== 1'b0) begin
            errors++; $display("FAIL abort_pre: got busy=%b ab=%b required busy=1 ab=0", busy, aborted);
        end
        @(negedge clk);
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_pulse: got ab=%b busy=%b required ab=1 busy=0", aborted, busy);
        end
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0 || ab_cnt !== 1 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL abort_once: got ab=%b ab_cycles=%0d ov_cycles=%0d required 0/1/0",
                     aborted, ab_cnt, ov_cnt);
        end
        stream(3, 256);
        checks++;
        if (out_valid !== 1'b1 || ones_count !== 9'd64 || result !== 19'd65536) begin
            errors++;
            $display("FAIL abort_next: got ov=%b ones=%0d res=%0d required ov=1 ones=64 res=65536",
                     out_valid, ones_count, result);
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        stream(2, 256);
        checks++;
        if (out_valid !== 1'b1 || ones_count !== 9'd128) begin
            errors++; $display("FAIL bp_start: got ov=%b ones=%0d required ov=1 ones=128", out_valid, ones_count);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || ones_count !== 9'd128 || result !== 19'd131072 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ones=%0d res=%0d busy=%b required 1/128/131072/0",
                         i, out_valid, ones_count, result, busy);
            end
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 19'd131072) begin
            errors++;
            $display("FAIL bp_release: got ov=%b busy=%b res=%0d required ov=0 busy=0 res=131072",
                     out_valid, busy, result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_accum();
        ab_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy: got %b required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, ones_count, busy, aborted} !== '0) begin
            errors++;
            $display("FAIL rst_async: got ov=%b res=%0d ones=%0d busy=%b ab=%b required all 0",
                     out_valid, result, ones_count, busy, aborted);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (ab_cnt !== 0) begin
            errors++; $display("FAIL rst_no_abort: got %0d abort cycles required 0", ab_cnt);
        end
        stream(0, 256);
        checks++;
        if (out_valid !== 1'b1 || ones_count !== 9'd256 || result !== 19'd262144) begin
            errors++;
            $display("FAIL rst_after: got ov=%b ones=%0d res=%0d required ov=1 ones=256 res=262144",
                     out_valid, ones_count, result);
        end
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_back_to_back();
        test_abort();
        test_backpressure();
        test_reset_mid_accum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_dot_product_decoder.md
# sc_dot_product_decoder

Receive-side decoder for the stochastic dot-product datapath: takes the single-bit scaled-sum stream produced by `sc_dot_product` (with its `valid`), counts ones over a fixed window of 2^WIDTH bits, and rescales the count back to the binary integer domain of the original WIDTH-bit data and weight operands. It replaces ad-hoc framing and `last` generation in front of `sd_converter`. It presents one registered result per window on a valid/ready handshake.

## Interface
- `WIDTH`, 8, operand bit width; window length L = 2^WIDTH stream bits.
- `DIMENSION`, 4, vector length; must be a power of two ≥ 2.
- `OUT_W`, 2*WIDTH + clogb2(DIMENSION) + 1, derived result width (19 for defaults).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: stream bit qualifier (driven from `sc_dot_product.valid`).
- `in_bit` in 1: stochastic result bit (driven from `sc_dot_product.result`).
- `out_ready` in 1: consumer accepts the result.
- `out_valid` out 1: `result`/`ones_count` valid; held until accepted.
- `result` out OUT_W: rescaled dot product = ones_count << (WIDTH + clogb2(DIMENSION)).
- `ones_count` out WIDTH+1: raw ones count of the window, range 0..L.
- `busy` out 1: high in ACCUM.
- `aborted` out 1: one-cycle pulse when a window is abandoned.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: on an edge with `in_valid`=1, capture sample 0 (acc = `in_bit`, sample_cnt = 1) and go to ACCUM. Otherwise stay.
- ACCUM, `in_valid`=1: acc += `in_bit`, sample_cnt += 1. When the captured sample is sample L-1, register `ones_count` = final acc and `result` = final acc shifted left by WIDTH+clogb2(DIMENSION), set `out_valid`, and go to DONE.
- ACCUM, `in_valid`=0: abandon the window. Clear acc and sample_cnt, pulse `aborted` for one cycle, and go to IDLE. No result is produced.
- DONE: `out_valid`, `result` and `ones_count` hold stable. Stream bits are ignored.
- DONE, edge with `out_valid`&&`out_ready`: clear `out_valid` and go to IDLE. A stream bit on that same edge is not captured, so there is a minimum one-cycle gap between windows.
- Arithmetic:
  - acc and sample_cnt are WIDTH+1 bits wide and never wrap, because the window ends at sample L-1.
  - The shift is lossless into OUT_W bits; the maximum is L << (WIDTH+log2 DIMENSION) = DIMENSION·2^(2·WIDTH).
  - `result` estimates Σ data_i·weight_i. Quantisation step is DIMENSION·2^WIDTH.
- `rst` asserted in any state:
  - Asynchronously force IDLE and clear acc and sample_cnt.
  - Force `out_valid`=0, `result`=0, `ones_count`=0, `busy`=0, `aborted`=0.
  - Any partial window is discarded silently, with no `aborted` pulse.

## Timing
- Reset values: all outputs 0.
- Window start: the first edge with `in_valid`=1 while in IDLE.
- `busy` rises after that edge and falls after the edge capturing sample L-1.
- Latency: `out_valid` is high in the cycle immediately after the edge that captured sample L-1. For a gap-free stream, that is L cycles after the window-start edge.
- `out_valid` stays high until the handshake edge. With `out_ready` tied high it is a single-cycle pulse.
- `aborted` is high for exactly the one cycle following the edge where `in_valid`=0 was sampled in ACCUM.
- `result` and `ones_count` change only on the edge that sets `out_valid`.

## Test plan
- **All-ones window** (defaults): `in_valid`=1, `in_bit`=1 for 256 cycles, `out_ready`=1.
  - `ones_count`=256, `result`=262144.
  - `out_valid` is high for exactly one cycle, the cycle after the 256th sample edge.
- **All-zeros window**: 256 zero bits.
  - `ones_count`=0, `result`=0, `out_valid` pulses once.
- **Alternating 1,0 pattern for 256 samples**:
  - `ones_count`=128, `result`=131072.
  - A second back-to-back window after the one-cycle gap yields the same values.
- **Abort**: drop `in_valid` after 100 samples.
  - `aborted` pulses one cycle, no `out_valid`, `busy` falls.
  - A following full window of 64 ones then 192 zeros gives `ones_count`=64, `result`=65536.
- **Backpressure**: hold `out_ready`=0 for 20 cycles after `out_valid`, driving random `in_bit` with `in_valid`=1.
  - `result` and `ones_count` stay stable and no bits are counted.
  - On the handshake edge `out_valid` falls and the FSM returns to IDLE.
- **Reset mid-ACCUM**: assert `rst` asynchronously (between edges) at sample 150.
  - All outputs go to 0 immediately, with no `aborted` pulse.
  - After release, a full all-ones window gives `ones_count`=256.
